// File: rtl/mlp_pkg.sv
// Shared types and sizing helpers for the MLP inference controller.
package mlp_pkg;

    localparam int N_DEF      = 16;
    localparam int LAYERS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_W = 3'd1,
        MAC    = 3'd2,
        DRAIN  = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic int w_aw(input int n, input int layers);
        return $clog2(layers * n * n);
    endfunction

    function automatic int x_aw(input int n);
        return $clog2(n);
    endfunction

    function automatic int l_w(input int layers);
        return $clog2(layers) + 1;
    endfunction

endpackage

// File: rtl/mlp_wrap_cnt.sv
// Up-counter that returns to zero on the cycle it is enabled at MAX.
module mlp_wrap_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == W'(MAX));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mlp_ctrl.sv
// Sequencer for a weight-stationary MLP: loads the weight image, then walks
// layers/neurons/inputs issuing memory reads, accumulate strobes and write-backs.
module mlp_ctrl
    import mlp_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int LAYERS = LAYERS_DEF,
    parameter int W_AW   = w_aw(N, LAYERS),
    parameter int X_AW   = x_aw(N)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_valid_i,
    output logic                     start_ready_o,
    input  logic                     init_valid_i,
    output logic                     init_ready_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic                     w_ren_o,
    output logic                     w_wen_o,
    output logic [W_AW-1:0]          w_addr_o,
    output logic                     x_ren_o,
    output logic                     x_wen_o,
    output logic                     x_sel_o,
    output logic [X_AW-1:0]          x_addr_o,
    output logic                     acc_en_o,
    output logic                     acc_clr_o,
    output logic [$clog2(LAYERS):0]  layer_o,
    output logic                     busy_o
);

    localparam int LW = l_w(LAYERS);

    state_t state_q, state_d;
    logic   x_sel_q, x_sel_d;

    logic [W_AW-1:0] i_cnt;
    logic [X_AW-1:0] k_cnt;
    logic [X_AW-1:0] j_cnt;
    logic [LW-1:0]   l_cnt;
    logic i_wrap, k_wrap, j_wrap, l_wrap;
    logic start_acc;

    assign start_acc = (state_q == IDLE) && !init_valid_i && start_valid_i;

    mlp_wrap_cnt #(.W(W_AW), .MAX(LAYERS*N*N-1)) u_i_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (1'b0),
        .en_i  ((state_q == INIT_W) && init_valid_i),
        .cnt_o (i_cnt),
        .wrap_o(i_wrap)
    );

    mlp_wrap_cnt #(.W(X_AW), .MAX(N-1)) u_k_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (start_acc),
        .en_i  (state_q == MAC),
        .cnt_o (k_cnt),
        .wrap_o(k_wrap)
    );

    mlp_wrap_cnt #(.W(X_AW), .MAX(N-1)) u_j_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (start_acc),
        .en_i  (state_q == WB),
        .cnt_o (j_cnt),
        .wrap_o(j_wrap)
    );

    // The last layer wraps l back to 0 on the final write-back.
    mlp_wrap_cnt #(.W(LW), .MAX(LAYERS-1)) u_l_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (start_acc),
        .en_i  ((state_q == WB) && j_wrap),
        .cnt_o (l_cnt),
        .wrap_o(l_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_sel_q <= x_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_sel_d = x_sel_q;
        unique case (state_q)
            IDLE: begin
                if (init_valid_i) begin
                    state_d = INIT_W;
                end else if (start_valid_i) begin
                    state_d = MAC;
                    x_sel_d = 1'b0;
                end
            end
            INIT_W: if (i_wrap) state_d = IDLE;
            MAC:    if (k_wrap) state_d = DRAIN;
            DRAIN:  state_d = WB;
            WB: begin
                state_d = MAC;
                if (j_wrap) begin
                    x_sel_d = !x_sel_q;
                    if (l_wrap) state_d = DONE;
                end
            end
            DONE:   if (result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready_o  = 1'b0;
        init_ready_o   = 1'b0;
        result_valid_o = 1'b0;
        w_ren_o        = 1'b0;
        w_wen_o        = 1'b0;
        w_addr_o       = '0;
        x_ren_o        = 1'b0;
        x_wen_o        = 1'b0;
        x_addr_o       = '0;
        acc_en_o       = 1'b0;
        acc_clr_o      = 1'b0;
        unique case (state_q)
            IDLE: start_ready_o = rst_ni && !init_valid_i;
            INIT_W: begin
                init_ready_o = 1'b1;
                if (init_valid_i) begin
                    w_wen_o  = 1'b1;
                    w_addr_o = i_cnt;
                end
            end
            MAC: begin
                w_ren_o  = 1'b1;
                x_ren_o  = 1'b1;
                w_addr_o = W_AW'(int'(l_cnt) * N * N + int'(j_cnt) * N + int'(k_cnt));
                x_addr_o = k_cnt;
                // Data for the read issued one cycle earlier arrives now.
                acc_en_o  = (k_cnt != '0);
                acc_clr_o = (k_cnt == X_AW'(1));
            end
            DRAIN: acc_en_o = 1'b1;
            WB: begin
                x_wen_o  = 1'b1;
                x_addr_o = j_cnt;
            end
            DONE: result_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign x_sel_o = x_sel_q;
    assign layer_o = ($clog2(LAYERS)+1)'(l_cnt);

endmodule

// File: tb/tb_mlp_ctrl.sv
// Randomized bench for mlp_ctrl with a timeline-based reference model.
module tb_mlp_ctrl;

    localparam int N      = 4;
    localparam int LAYERS = 2;
    localparam int TOT    = LAYERS * N * N;
    localparam int LAT    = LAYERS * N * (N + 2);
    localparam int W_AW   = $clog2(TOT);
    localparam int X_AW   = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_v = 1'b0;
    logic init_v = 1'b0;
    logic res_ready = 1'b0;
    logic start_ready, init_ready, result_valid;
    logic w_ren, w_wen, x_ren, x_wen, x_sel, acc_en, acc_clr, busy;
    logic [W_AW-1:0] w_addr;
    logic [X_AW-1:0] x_addr;
    logic [$clog2(LAYERS):0] layer;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 loading, 2 computing, 3 done.
    int m_phase = 0;
    int m_wcnt = 0;
    int m_off = 0;
    bit m_xsel = 1'b0;
    bit m_live = 1'b0;

    always #5 clk = ~clk;

    mlp_ctrl #(.N(N), .LAYERS(LAYERS)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (start_v),
        .start_ready_o (start_ready),
        .init_valid_i  (init_v),
        .init_ready_o  (init_ready),
        .result_valid_o(result_valid),
        .result_ready_i(res_ready),
        .w_ren_o       (w_ren),
        .w_wen_o       (w_wen),
        .w_addr_o      (w_addr),
        .x_ren_o       (x_ren),
        .x_wen_o       (x_wen),
        .x_sel_o       (x_sel),
        .x_addr_o      (x_addr),
        .acc_en_o      (acc_en),
        .acc_clr_o     (acc_clr),
        .layer_o       (layer),
        .busy_o        (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        int n, p;
        if (!rst_n) begin
            m_phase = 0;
            m_wcnt = 0;
            m_off = 0;
            m_xsel = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (init_v) begin
                        m_phase = 1;
                        m_wcnt = 0;
                    end else if (start_v) begin
                        m_phase = 2;
                        m_off = 0;
                        m_xsel = 1'b0;
                    end
                end
                1: begin
                    if (init_v) begin
                        if (m_wcnt == TOT - 1) begin
                            m_phase = 0;
                            m_wcnt = 0;
                        end else begin
                            m_wcnt++;
                        end
                    end
                end
                2: begin
                    n = m_off / (N + 2);
                    p = m_off % (N + 2);
                    if (p == N + 1 && n % N == N - 1) m_xsel = ~m_xsel;
                    m_off++;
                    if (m_off == LAT) m_phase = 3;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        int n, p, l, j, ewa, exa;
        bit cp, rd, wb, wen;
        if (m_live) begin
            cp = (m_phase == 2);
            n = m_off / (N + 2);
            p = m_off % (N + 2);
            l = n / N;
            j = n % N;
            rd = cp && p < N;
            wb = cp && p == N + 1;
            wen = (m_phase == 1) && init_v;
            ewa = rd ? l * N * N + j * N + p : (wen ? m_wcnt : 0);
            exa = rd ? p : (wb ? j : 0);
            chk("start_ready", start_ready, (m_phase == 0) && !init_v && rst_n);
            chk("init_ready", init_ready, m_phase == 1);
            chk("result_valid", result_valid, m_phase == 3);
            chk("busy", busy, m_phase != 0);
            chk("w_wen", w_wen, wen);
            chk("w_ren", w_ren, rd);
            chk("x_ren", x_ren, rd);
            chk("w_addr", w_addr, ewa);
            chk("x_addr", x_addr, exa);
            chk("x_wen", x_wen, wb);
            chk("acc_en", acc_en, cp && p >= 1 && p <= N);
            chk("acc_clr", acc_clr, cp && p == 1);
            chk("x_sel", x_sel, m_xsel);
            chk("layer", layer, cp ? l : 0);
        end
    end

    task automatic run_init(input bit entered);
        if (!entered) begin
            init_v = 1'b1;
            step();
        end
        for (int i = 0; i < 400 && m_phase != 0; i++) begin
            init_v = 1'($urandom_range(0, 1));
            step();
        end
        init_v = 1'b0;
        chk("init_timeout", m_phase, 0);
    endtask

    task automatic run_compute();
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        for (int i = 0; i < 400 && m_phase != 0; i++) begin
            res_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        res_ready = 1'b0;
        chk("compute_timeout", m_phase, 0);
    endtask

    initial begin
        int nw, last, lat;
        repeat (3) step();
        chk("rst_start_ready", start_ready, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        chk("idle_start_ready", start_ready, 1);

        // Full weight load with valid held high.
        init_v = 1'b1;
        nw = 0;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_wen) begin
                nw++;
                last = int'(w_addr);
            end
            if (nw == TOT) break;
        end
        step();
        init_v = 1'b0;
        chk("init_words", nw, 32);
        chk("init_last_addr", last, 31);
        chk("init_ready_after", init_ready, 0);
        chk("busy_after_init", busy, 0);

        run_init(1'b0);

        // Directed inference run with held-off result consumer.
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        lat = 0;
        while (!result_valid && lat < 200) begin
            if (lat < 4) chk("first_waddr", w_addr, lat);
            if (lat == 5) begin
                chk("wb0_wen", x_wen, 1);
                chk("wb0_addr", x_addr, 0);
                chk("wb0_sel", x_sel, 0);
            end
            if (lat == 24) begin
                chk("l1_waddr", w_addr, 16);
                chk("l1_sel", x_sel, 1);
                chk("l1_layer", layer, 1);
            end
            step();
            lat++;
        end
        chk("latency", lat, 48);
        chk("done_sel", x_sel, 0);
        for (int i = 0; i < 10; i++) begin
            chk("done_hold", result_valid, 1);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("done_exit_valid", result_valid, 0);
        chk("done_exit_busy", busy, 0);

        // Simultaneous start and init: init wins.
        start_v = 1'b1;
        init_v = 1'b1;
        #1;
        chk("both_start_ready", start_ready, 0);
        step();
        start_v = 1'b0;
        chk("both_init_ready", init_ready, 1);
        run_init(1'b1);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) step();
            run_compute();
        end

        // Reset during the 20th MAC cycle.
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        for (int i = 0; i < 60 && m_off != 27; i++) step();
        chk("mac20_ren", w_ren, 1);
        rst_n = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_ren", w_ren, 0);
        chk("abort_acc", acc_en, 0);
        chk("abort_sel", x_sel, 0);
        chk("abort_waddr", w_addr, 0);
        rst_n = 1'b1;
        step();
        run_compute();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
